cpu_fetch: RTL
==============

# cpu_fetch

Instruction fetch stage of the accelerator's 5-stage CPU pipeline. It drives the synchronous instruction memory, presents the instruction currently in IF to `cpu_stall` (`if_instr`), and consumes `rw_stall` and `jb_stall` from it. It holds the IF instruction across stalls, redirects on taken branches from EXEC, and loads the IF/DEC pipeline register.

## Interface
- `PC_W`, 16: word-address width of the PC and imem.
- `RESET_PC`, 0: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `rw_stall` in 1: register hazard from `cpu_stall`; hold the IF instruction.
- `jb_stall` in 1: jump/branch in flight from `cpu_stall`; hold the IF instruction.
- `br_taken` in 1: one-cycle redirect pulse from EXEC.
- `br_target` in PC_W: redirect address, valid with `br_taken`.
- `imem_addr` out PC_W: fetch address.
- `imem_rd_en` out 1: read strobe.
- `imem_rdata` in 32: read data, valid the cycle after the strobe.
- `if_instr` out 32: combinational instruction in IF, fed to `cpu_stall`.
- `if_valid` out 1: `if_instr` is a real instruction.
- `dec_instr` out 32: IF/DEC register instruction.
- `dec_pc` out PC_W: IF/DEC register PC.
- `dec_valid` out 1: IF/DEC register holds a real instruction.
- `halted` out 1: fetch stopped by HALT.

## Operation
- NOP encoding is 32'h0000_0000. HALT is opcode `[31:24]` = 8'hFF.
- Internal state:
  - `pc`: next fetch address.
  - `resp_valid`, `resp_pc`: read issued last cycle.
  - `hold_valid`, `hold_instr`, `hold_pc`: skid register.
  - `state` in {RUN, HALT}.
- Presented instruction, in priority order:
  - `hold_valid`: present `hold_instr` / `hold_pc`.
  - else `resp_valid`: present `imem_rdata` / `resp_pc`.
  - else present NOP and `if_valid`=0.
- `stall` = `rw_stall | jb_stall`.
- `adv` = `!rst & state==RUN & !stall & !br_taken`.
  - `imem_rd_en` = `adv`; `imem_addr` = `pc`.
  - On `adv`: `pc`<=`pc`+1 (wraps modulo 2^PC_W), `resp_valid`<=1, `resp_pc`<=`pc`. Otherwise `resp_valid`<=0.
- Consume = `if_valid & !stall & !br_taken`.
  - On consume: `dec_instr`/`dec_pc` <= presented values, `dec_valid`<=1, and `hold_valid`<=0.
  - Otherwise `dec_instr`<=NOP and `dec_valid`<=0; `dec_pc` holds its value.
- Skid: if presented from resp (not hold) and not consumed and not `br_taken`, then `hold_instr`/`hold_pc` <= `imem_rdata`/`resp_pc` and `hold_valid`<=1.
- Branch: `br_taken` has top priority in RUN. It sets `pc`<=`br_target`, `hold_valid`<=0, `resp_valid`<=0, and forces a NOP into IF/DEC. This applies even when a stall is asserted in the same cycle.
- HALT: when a consumed instruction has opcode 8'hFF, `state`<=HALT. That HALT instruction still enters IF/DEC.
  - In HALT: no reads, `if_valid`=0, `br_taken` ignored, `halted`=1.
  - Only `rst` exits HALT.
- Reset values:
  - `pc`=RESET_PC, `state`=RUN.
  - `resp_valid`=0, `hold_valid`=0.
  - `dec_instr`=0, `dec_pc`=0, `dec_valid`=0, `halted`=0.
  - `imem_rd_en`=0 while `rst` is high.
  - Reset mid-stall or mid-redirect discards all held and in-flight instructions.

## Timing
- Cycle 0 after reset release: `imem_rd_en`=1, `imem_addr`=RESET_PC.
- Cycle 1: `if_instr`=mem[RESET_PC], `if_valid`=1.
- Cycle 2: `dec_instr`=mem[RESET_PC].
- Fetch-to-decode latency is 2 cycles; unstalled throughput is one instruction per cycle.
- Stall of N cycles starting while instruction X is presented:
  - X is captured into hold on the first stall cycle.
  - `if_instr`=X for all N cycles; `dec_valid`=0 for N cycles.
  - On the first non-stall cycle, X is consumed from hold and the next read issues. Its data appears one cycle later, so exactly one extra bubble follows every stall.
- `br_taken` at cycle t:
  - Cycle t+1: read of `br_target`.
  - Cycle t+2: `if_instr`=mem[`br_target`].
  - `dec_valid`=0 at t+1 and t+2.
- `halted` rises the cycle after the HALT instruction is consumed.

## Test plan
- Reset, then free-run with mem[i]=32'h1000_0000+i → `dec_instr` sequence 32'h1000_0000, 32'h1000_0001, … starting cycle 2, `dec_pc`=0,1,2…, no gaps.
- `rw_stall` high for 3 cycles while mem[5] is presented → `if_instr`=mem[5] for 3 cycles, then mem[5] enters decode, one bubble, then mem[6]; no instruction lost or duplicated.
- `jb_stall` for 2 cycles followed by `br_taken` with `br_target`=16'h0040 → held instruction dropped, `imem_addr`=16'h0040 next cycle, `dec_instr`=mem[16'h40] two cycles after that.
- `br_taken` with `rw_stall` in the same cycle → redirect wins; hold cleared; next consumed instruction is mem[`br_target`].
- mem[3]=32'hFF00_0000 → HALT reaches `dec_instr`; `halted`=1 the next cycle; `imem_rd_en` stays 0; a later `br_taken` is ignored; `rst` restarts at RESET_PC.
- PC_W=4, RESET_PC=15 → fetch order 15, 0, 1 (wrap-around).

Source files
------------

// File: rtl/cpu_fetch.sv
// Instruction fetch stage of the 5-stage CPU pipeline.
// Drives the synchronous instruction memory, presents the IF instruction to
// the stall unit, keeps it in a skid register across stalls, redirects on
// taken branches and loads the IF/DEC pipeline register.
module cpu_fetch #(
    parameter int unsigned         PC_W     = 16,
    parameter logic [PC_W-1:0]     RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rw_stall,
    input  logic            jb_stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd_en,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     if_instr,
    output logic            if_valid,
    output logic [31:0]     dec_instr,
    output logic [PC_W-1:0] dec_pc,
    output logic            dec_valid,
    output logic            halted
);

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [7:0]  HALT_OP = 8'hFF;

    typedef enum logic {
        S_RUN,
        S_HALT
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            resp_valid;
    logic [PC_W-1:0] resp_pc;
    logic            hold_valid;
    logic [31:0]     hold_instr;
    logic [PC_W-1:0] hold_pc;

    logic            run;
    logic            stall;
    logic            adv;
    logic            consume;
    logic [31:0]     pres_instr;
    logic [PC_W-1:0] pres_pc;

    // Fetch control: a new read issues only when running, unstalled and not redirecting.
    always_comb begin
        run        = (state == S_RUN);
        stall      = rw_stall | jb_stall;
        adv        = !rst && run && !stall && !br_taken;
        imem_rd_en = adv;
        imem_addr  = pc;
    end

    // Presented instruction: skid register first, then the memory response, else a NOP.
    always_comb begin
        pres_instr = NOP;
        pres_pc    = '0;
        if (hold_valid) begin
            pres_instr = hold_instr;
            pres_pc    = hold_pc;
        end else if (resp_valid) begin
            pres_instr = imem_rdata;
            pres_pc    = resp_pc;
        end
        // A read issued in the cycle HALT was consumed is never presented.
        if_valid = run && (hold_valid || resp_valid);
        if_instr = if_valid ? pres_instr : NOP;
        consume  = if_valid && !stall && !br_taken;
    end

    // Sequential state: PC, in-flight read, skid register, IF/DEC register and run/halt FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RUN;
            pc         <= RESET_PC;
            resp_valid <= 1'b0;
            resp_pc    <= '0;
            hold_valid <= 1'b0;
            hold_instr <= NOP;
            hold_pc    <= '0;
            dec_instr  <= NOP;
            dec_pc     <= '0;
            dec_valid  <= 1'b0;
        end else if (state == S_RUN) begin
            if (br_taken) begin
                // Redirect beats any stall: drop held and in-flight words.
                pc         <= br_target;
                resp_valid <= 1'b0;
                hold_valid <= 1'b0;
                dec_instr  <= NOP;
                dec_valid  <= 1'b0;
            end else begin
                if (adv) begin
                    pc         <= pc + PC_W'(1);
                    resp_valid <= 1'b1;
                    resp_pc    <= pc;
                end else begin
                    resp_valid <= 1'b0;
                end

                if (consume) begin
                    dec_instr  <= pres_instr;
                    dec_pc     <= pres_pc;
                    dec_valid  <= 1'b1;
                    hold_valid <= 1'b0;
                    if (pres_instr[31:24] == HALT_OP) begin
                        state <= S_HALT;
                    end
                end else begin
                    dec_instr <= NOP;
                    dec_valid <= 1'b0;
                    // Memory data is only valid for one cycle, so capture it when stalled.
                    if (!hold_valid && resp_valid) begin
                        hold_valid <= 1'b1;
                        hold_instr <= imem_rdata;
                        hold_pc    <= resp_pc;
                    end
                end
            end
        end else begin
            resp_valid <= 1'b0;
            hold_valid <= 1'b0;
            dec_instr  <= NOP;
            dec_valid  <= 1'b0;
        end
    end

    assign halted = (state == S_HALT);

endmodule
